// File: rtl/tuple_stream_gen.sv
`default_nettype none
// ============================================================================
// Module      : tuple_stream_gen
// Description : Emits a stream of LANES-wide tuples; lane k yields
//               base_k + i*step_k for i = 0..count-1, with a valid/ready
//               handshake on the output. Lane arithmetic wraps modulo
//               2^WIDTH.
//               Optional feature macro: TUPLE_STREAM_GEN_LAST_EN adds a
//               _last output flagging the final tuple of a sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tuple_stream_gen #(
    parameter int WIDTH = 32,
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic                   _clock,
    input  logic                   _reset_n,
    input  logic                   _start,
    input  logic [LANES*WIDTH-1:0] _base,
    input  logic [LANES*WIDTH-1:0] _step,
    input  logic [CNT_W-1:0]       _count,
    input  logic                   _ready,
    output logic [LANES*WIDTH-1:0] _out,
    output logic                   _valid,
    output logic                   _done
`ifdef TUPLE_STREAM_GEN_LAST_EN
    ,
    output logic                   _last
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_acc  [LANES];
    logic [WIDTH-1:0] r_step [LANES];
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_index;

    logic [CNT_W-1:0] w_count_m1;
    logic             w_is_last;
    logic             w_xfer;
    logic             w_load;

    // Final-element detect; r_count is never zero while in RUN, so the
    // decrement cannot underflow there. index stops at count-1 and so never
    // has to represent count itself, even at the maximum count.
    assign w_count_m1 = r_count - CNT_W'(1);
    assign w_is_last  = (r_index == w_count_m1);
    assign w_xfer     = (r_state == S_RUN) && _ready;
    assign w_load     = (r_state == S_IDLE) && _start;

    // State register
    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs; _valid is decoded from state only,
    // so it never depends combinationally on _ready
    always_comb begin
        w_state_next = r_state;
        _valid       = 1'b0;
        _done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (_start) begin
                    w_state_next = (_count == '0) ? S_FINISH : S_RUN;
                end
            end
            S_RUN: begin
                _valid = 1'b1;
                if (_ready && w_is_last) begin
                    w_state_next = S_FINISH;
                end
            end
            S_FINISH: begin
                _done        = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Argument latching and per-lane accumulation; the final transfer leaves
    // the accumulators and index untouched
    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) begin
            for (int k = 0; k < LANES; k++) begin
                r_acc[k]  <= '0;
                r_step[k] <= '0;
            end
            r_count <= '0;
            r_index <= '0;
        end else if (w_load) begin
            for (int k = 0; k < LANES; k++) begin
                r_acc[k]  <= _base[k*WIDTH +: WIDTH];
                r_step[k] <= _step[k*WIDTH +: WIDTH];
            end
            r_count <= _count;
            r_index <= '0;
        end else if (w_xfer && !w_is_last) begin
            for (int k = 0; k < LANES; k++) begin
                r_acc[k] <= r_acc[k] + r_step[k];
            end
            r_index <= r_index + CNT_W'(1);
        end
    end

    // Pack the accumulators onto the output bus, lane k at [k*WIDTH +: WIDTH]
    for (genvar g = 0; g < LANES; g++) begin : g_lane_out
        assign _out[g*WIDTH +: WIDTH] = r_acc[g];
    end

`ifdef TUPLE_STREAM_GEN_LAST_EN
    // Final-tuple flag; held under backpressure because index is frozen
    assign _last = _valid && w_is_last;
`endif

endmodule
`default_nettype wire

// File: doc/tuple_stream_gen.md
Name: tuple_stream_gen

Overview:
- Parametrised successor to the fixed 4-output generator modules.
- Emits a stream of LANES-wide tuples. Lane k yields base_k + i*step_k for i = 0..count-1.
- The output is flow-controlled by a valid/ready handshake, so downstream consumers can apply backpressure.
- Sits between the argument-latching front end and any consumer of generated sequences, such as drawing or checking logic.

Parameters:
- WIDTH, 32, bit width of each signed lane value.
- LANES, 4, number of parallel output lanes in each tuple.
- CNT_W, 16, width of the element-count input and the internal index.

Ports:
- _clock  input  1  single clock; all state updates on its rising edge.
- _reset_n  input  1  asynchronous, active-low reset.
- _start  input  1  request to begin a new sequence; sampled only in IDLE.
- _base  input  LANES*WIDTH  per-lane signed start values; lane k is at bits [k*WIDTH +: WIDTH].
- _step  input  LANES*WIDTH  per-lane signed increments; same packing as _base.
- _count  input  CNT_W  number of tuples to emit (unsigned).
- _ready  input  1  consumer can accept the current tuple.
- _out  output  LANES*WIDTH  current tuple; same packing as _base.
- _valid  output  1  _out holds a valid tuple.
- _done  output  1  one-cycle pulse when the sequence completes.

Behaviour:
- Reset (async, _reset_n=0):
  - state=IDLE.
  - _valid=0, _done=0, _out=0, index=0.
  - All latched arguments cleared.
- States: IDLE, RUN, FINISH.
- IDLE:
  - _valid=0, _done=0.
  - On a clock edge with _start=1, latch _base, _step and _count into internal registers, and load the per-lane accumulators with _base.
  - If _count==0, go to FINISH. Otherwise go to RUN with index=0.
- Latency: _start sampled at edge t → _valid=1 with _out=base from edge t+1.
- RUN:
  - _valid=1 and _out = accumulators.
  - Handshake: a transfer occurs on an edge where _valid&&_ready.
  - On a transfer with index < count-1: each accumulator += its step; index += 1; stay in RUN.
  - On a transfer with index == count-1: go to FINISH; _valid drops on the next cycle.
  - With _ready=0, _out and _valid stay stable (no lane changes, no index change).
  - _valid never depends combinationally on _ready.
- FINISH:
  - _valid=0, _done=1 for exactly one cycle, then IDLE.
  - The earliest new _start is sampled in the IDLE cycle that follows.
- Arithmetic: per-lane two's-complement addition modulo 2^WIDTH. Overflow wraps silently with no flag.
- Arguments: changes to _base, _step or _count after latching have no effect on the running sequence.
- _start outside IDLE (RUN/FINISH) is ignored; it is not queued.
- Throughput: one tuple per cycle while _ready is held high. _count=N with _ready=1 gives N consecutive valid cycles.
- _count at its maximum (2^CNT_W-1) is supported; index must not wrap before termination.
- Reset asserted mid-RUN: immediate return to IDLE and outputs cleared. No _done pulse.

Optional Feature:
- Macro: TUPLE_STREAM_GEN_LAST_EN.
- Defined: an extra output port _last (1 bit) is added. _last=1 exactly when _valid=1 and index==count-1, and is held under backpressure. The reset value of _last is 0.
- Undefined: the port is absent. All other behaviour is identical.

Test Plan:
- Basic: LANES=4, base={1,2,3,4}, step={1,1,1,1}, count=3, _ready=1.
  → Tuples (1,2,3,4), (2,3,4,5), (3,4,5,6) on consecutive cycles starting one cycle after _start.
  → _done pulses the cycle after the last tuple.
- Backpressure: same setup, with _ready low on the 2nd valid cycle for 3 cycles.
  → _out stays (2,3,4,5) with _valid=1 throughout.
  → Exactly 3 transfers total; _done follows the third transfer.
- Zero count and ignored start: count=0.
  → _valid never rises; _done pulses the cycle after _start.
  → A second _start during RUN of a count=5 run emits exactly 5 tuples.
- Wrap and negative steps: WIDTH=8, base={127,-128,0,5}, step={1,-1,-3,0}, count=2.
  → Second tuple is (-128,127,-3,5).
- Reset mid-operation: assert _reset_n=0 during RUN of count=10 after 4 transfers.
  → _valid=0 and _out=0 immediately, with no _done pulse.
  → A new start with count=2 then produces 2 tuples from the new base.
- Macro build: define TUPLE_STREAM_GEN_LAST_EN, count=3, _ready toggling.
  → _last=1 only on the third tuple and held while _ready=0. _last=0 after reset.
